pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl.sv | 73 +++++++
 tb/tb_pc_fetch_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch controller for a byte-addressed instruction store.
// Picks the next fetch address, range-checks it and halts on an illegal target.
module pc_fetch_ctrl #(
  parameter int unsigned MEM_BYTES = 100,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        restart,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  // Highest byte address at which a full 32-bit word still fits in the store.
  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 32'd4);

  state_t      state;
  logic [31:0] candidate;
  logic        legal;

  assign pc_plus4 = pc + 32'd4;

  // NOTE: candidate gets a default before the priority chain so no latch is inferred.
  always_comb begin
    candidate = pc_plus4;
    if (jr)
      candidate = jr_addr;
    else if (jump)
      candidate = {pc_plus4[31:28], jump_index, 2'b00};
    else if (branch_taken)
      candidate = pc_plus4 + (branch_offset << 2);
  end

  assign legal = (candidate[1:0] == 2'b00) && (candidate <= LAST_PC);

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      fault       <= 1'b0;
      fetch_count <= 32'd0;
    end else if (restart) begin
      // Restart reloads the pc but deliberately keeps the fetch history.
      state <= RUN;
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else if (state == RUN && !stall) begin
      if (legal) begin
        pc          <= candidate;
        fetch_count <= fetch_count + 32'd1;
      end else begin
        state <= HALT;
        fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl (MEM_BYTES=100, RESET_PC=0).
// Expected values are hand-computed per vector.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_addr;
  logic        restart;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;
  logic [31:0] fetch_count;

  int n_cmp = 0;
  int n_err = 0;

  pc_fetch_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_index   (jump_index),
    .jr           (jr),
    .jr_addr      (jr_addr),
    .restart      (restart),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fault        (fault),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, actual, actual, expected, expected);
    end
  endtask

  task automatic idle();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 32'd0;
    jump          = 1'b0;
    jump_index    = 26'd0;
    jr            = 1'b0;
    jr_addr       = 32'd0;
    restart       = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [31:0] e_pc, input logic e_fault,
                              input logic [31:0] e_cnt);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".fault"}, {31'd0, fault}, {31'd0, e_fault});
    check({tag, ".cnt"}, fetch_count, e_cnt);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #3;
    expect_state("reset", 32'd0, 1'b0, 32'd0);
    #9 rst_n = 1'b1;

    // Three idle edges walk the pc sequentially.
    tick(); check("seq1.pc", pc, 32'd4);
    tick(); check("seq2.pc", pc, 32'd8);
    tick(); expect_state("seq3", 32'd12, 1'b0, 32'd3);
    tick(); check("seq4.pc", pc, 32'd16);

    // Forward branch: 16+4+(3<<2)=32.
    branch_taken = 1'b1; branch_offset = 32'd3;
    tick(); expect_state("br_fwd", 32'd32, 1'b0, 32'd5);

    idle(); jr = 1'b1; jr_addr = 32'd16;
    tick(); check("jr16.pc", pc, 32'd16);

    // Backward branch: 16+4-8=12.
    idle(); branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFE;
    tick(); expect_state("br_back", 32'd12, 1'b0, 32'd7);

    // jr beats jump and branch.
    idle(); jr = 1'b1; jr_addr = 32'd40; jump = 1'b1; jump_index = 26'd3;
    branch_taken = 1'b1; branch_offset = 32'd1;
    tick(); expect_state("prio_jr", 32'd40, 1'b0, 32'd8);

    // Pseudo-direct jump: {0, 15, 00} = 60.
    idle(); jump = 1'b1; jump_index = 26'd15;
    tick(); check("jump.pc", pc, 32'd60);

    // jump beats branch: {0, 5, 00} = 20.
    idle(); jump = 1'b1; jump_index = 26'd5; branch_taken = 1'b1; branch_offset = 32'd0;
    tick(); expect_state("prio_jump", 32'd20, 1'b0, 32'd10);
    check("pc_plus4", pc_plus4, 32'd24);

    // Misaligned and out-of-range jr target halts.
    idle(); jr = 1'b1; jr_addr = 32'd98;
    tick(); expect_state("jr98", 32'd20, 1'b1, 32'd10);

    // HALT ignores redirects.
    jr_addr = 32'd8;
    tick(); expect_state("halt_hold", 32'd20, 1'b1, 32'd10);

    // Restart wins over a pending jr.
    restart = 1'b1;
    tick(); expect_state("restart1", 32'd0, 1'b0, 32'd10);

    // Last legal word address.
    idle(); jr = 1'b1; jr_addr = 32'd96;
    tick(); expect_state("jr96", 32'd96, 1'b0, 32'd11);

    // Sequential 100 is past the end.
    idle();
    tick(); expect_state("seq100", 32'd96, 1'b1, 32'd11);

    restart = 1'b1;
    tick(); check("restart2.pc", pc, 32'd0);

    // In-range but misaligned.
    idle(); jr = 1'b1; jr_addr = 32'd6;
    tick(); expect_state("jr6", 32'd0, 1'b1, 32'd11);

    idle(); restart = 1'b1;
    tick(); check("restart3.fault", {31'd0, fault}, 32'd0);

    idle();
    tick(); tick();
    expect_state("pre_stall", 32'd8, 1'b0, 32'd13);

    // Stall holds and masks the redirect.
    stall = 1'b1; jr = 1'b1; jr_addr = 32'd40;
    tick(); tick();
    expect_state("stall2", 32'd8, 1'b0, 32'd13);

    idle();
    tick(); expect_state("unstall", 32'd12, 1'b0, 32'd14);

    // Restart beats stall.
    restart = 1'b1; stall = 1'b1;
    tick(); expect_state("restart_stall", 32'd0, 1'b0, 32'd14);

    idle(); jr = 1'b1; jr_addr = 32'd98;
    tick(); check("halt_again.fault", {31'd0, fault}, 32'd1);

    // Asynchronous reset mid-cycle while halted.
    #1 rst_n = 1'b0;
    #1 expect_state("async_rst", 32'd0, 1'b0, 32'd0);
    idle();
    #6 rst_n = 1'b1;
    tick(); expect_state("post_rst", 32'd4, 1'b0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
